// File: rtl/clkgen_multi.sv
// Multi-channel programmable clock/tick generator: NCH square waves from clkin,
// each with a runtime-writable half-period applied glitch-free at boundaries.
//
// Ports:
//   clkin    system clock, all logic on its rising edge
//   rst_n    asynchronous reset, active low
//   en       per-channel run enable
//   sync     phase-align strobe for all channels
//   wr_en    half-period write strobe
//   wr_ch    channel index for the write (out-of-range writes are ignored)
//   wr_half  new half-period in clkin cycles (0 parks the channel)
//   clkout   divided square-wave outputs, registered
//   tick     one-cycle pulse on every clkout 0->1, registered
//   pending  written half-period not yet in use
module clkgen_multi #(
    parameter int NCH        = 4,
    parameter int CNT_W      = 32,
    parameter int CLKIN_FREQ = 50000000,
    parameter int DEF_FREQ   = 1000,
    parameter logic [CNT_W-1:0] DEF_HALF = CNT_W'(CLKIN_FREQ / 2 / DEF_FREQ),
    localparam int CH_W      = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clkin,
    input  logic             rst_n,
    input  logic [NCH-1:0]   en,
    input  logic             sync,
    input  logic             wr_en,
    input  logic [CH_W-1:0]  wr_ch,
    input  logic [CNT_W-1:0] wr_half,
    output logic [NCH-1:0]   clkout,
    output logic [NCH-1:0]   tick,
    output logic [NCH-1:0]   pending
);

    localparam logic [CH_W:0] NCH_L = (CH_W + 1)'(NCH);

    logic [NCH-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [NCH-1:0][CNT_W-1:0] sh_q, sh_d;
    logic [NCH-1:0][CNT_W-1:0] act_q, act_d;
    logic [NCH-1:0]            clk_q, clk_d;
    logic [NCH-1:0]            tick_q, tick_d;
    logic [CNT_W-1:0]          nxt;
    logic                      wr_ok;

    assign wr_ok = wr_en && ({1'b0, wr_ch} < NCH_L);

    always_comb begin
        cnt_d  = cnt_q;
        sh_d   = sh_q;
        act_d  = act_q;
        clk_d  = clk_q;
        tick_d = '0;
        nxt    = '0;
        for (int i = 0; i < NCH; i++) begin
            if (wr_ok && (wr_ch == CH_W'(i))) begin
                sh_d[i] = wr_half;
            end
            nxt = cnt_q[i] + CNT_W'(1);
            if (sync || (act_q[i] == '0)) begin
                // Restart from phase 0 with the current shadow value;
                // a write in this same cycle only reaches the shadow.
                cnt_d[i] = '0;
                clk_d[i] = 1'b0;
                act_d[i] = sh_q[i];
            end else if (!en[i]) begin
                cnt_d[i] = cnt_q[i];
            end else if (nxt >= act_q[i]) begin
                cnt_d[i] = '0;
                act_d[i] = sh_q[i];
                if (sh_q[i] == '0) begin
                    // Parking: end low rather than emit a stray high half.
                    clk_d[i] = 1'b0;
                end else begin
                    clk_d[i]  = ~clk_q[i];
                    tick_d[i] = ~clk_q[i];
                end
            end else begin
                cnt_d[i] = nxt;
            end
        end
    end

    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            sh_q   <= {NCH{DEF_HALF}};
            act_q  <= {NCH{DEF_HALF}};
            clk_q  <= '0;
            tick_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            sh_q   <= sh_d;
            act_q  <= act_d;
            clk_q  <= clk_d;
            tick_q <= tick_d;
        end
    end

    always_comb begin
        pending = '0;
        for (int i = 0; i < NCH; i++) begin
            pending[i] = (sh_q[i] != act_q[i]);
        end
    end

    assign clkout = clk_q;
    assign tick   = tick_q;

endmodule

// File: tb/tb_clkgen_multi.sv
// Testbench for clkgen_multi: directed scenarios plus random traffic,
// compared each cycle against a countdown-based reference model.
module tb_clkgen_multi;

    localparam int NCH = 3;
    localparam int CW  = 16;
    localparam int CHW = 2;

    logic           clkin = 1'b0;
    logic           rst_n = 1'b0;
    logic [NCH-1:0] en = '0;
    logic           sync = 1'b0;
    logic           wr_en = 1'b0;
    logic [CHW-1:0] wr_ch = '0;
    logic [CW-1:0]  wr_half = '0;
    logic [NCH-1:0] clkout, tick, pending;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clkin = ~clkin;

    clkgen_multi #(
        .NCH(NCH), .CNT_W(CW), .CLKIN_FREQ(1000), .DEF_FREQ(10),
        .DEF_HALF(16'd4)
    ) dut (
        .clkin(clkin), .rst_n(rst_n), .en(en), .sync(sync),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_half(wr_half),
        .clkout(clkout), .tick(tick), .pending(pending)
    );

    // Reference model: remaining cycles until the next edge.
    logic [NCH-1:0] m_lvl, m_tick;
    logic [CW-1:0]  m_sh [NCH];
    logic [CW-1:0]  m_act [NCH];
    int             m_rem [NCH];

    task automatic model_reset();
        m_lvl = '0;
        m_tick = '0;
        for (int i = 0; i < NCH; i++) begin
            m_sh[i] = 4; m_act[i] = 4; m_rem[i] = 4;
        end
    endtask

    task automatic model_update();
        logic [CW-1:0] nsh;
        for (int i = 0; i < NCH; i++) begin
            nsh = m_sh[i];
            if (wr_en && int'(wr_ch) < NCH && int'(wr_ch) == i) nsh = wr_half;
            m_tick[i] = 1'b0;
            if (sync || m_act[i] == 0) begin
                m_lvl[i] = 1'b0;
                m_act[i] = m_sh[i];
                m_rem[i] = int'(m_sh[i]);
            end else if (en[i]) begin
                m_rem[i] = m_rem[i] - 1;
                if (m_rem[i] == 0) begin
                    m_act[i] = m_sh[i];
                    m_rem[i] = int'(m_act[i]);
                    if (m_act[i] == 0) m_lvl[i] = 1'b0;
                    else begin
                        m_lvl[i] = ~m_lvl[i];
                        m_tick[i] = m_lvl[i];
                    end
                end
            end
            m_sh[i] = nsh;
        end
    endtask

    function automatic logic [NCH-1:0] exp_pend();
        logic [NCH-1:0] r;
        for (int i = 0; i < NCH; i++) r[i] = (m_sh[i] != m_act[i]);
        return r;
    endfunction

    task automatic step();
        model_update();
        @(posedge clkin);
        @(negedge clkin);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; sync = 1'b0; wr_en = 1'b0; en = '0;
        model_reset();
        @(negedge clkin);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = '0;
        model_reset();
        @(negedge clkin);
        n_chk++;
        if (clkout !== '0 || tick !== '0 || pending !== '0) begin
            n_fail++;
            $display("FAIL reset clkout=%b tick=%b pend=%b want 000", clkout, tick, pending);
        end
        rst_n = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            step();
            n_chk++;
            if (clkout !== m_lvl || tick !== m_tick || pending !== exp_pend()) begin
                n_fail++;
                $display("FAIL reset_idle c%0d clk=%b/%b tick=%b/%b pend=%b/%b",
                    c, clkout, m_lvl, tick, m_tick, pending, exp_pend());
            end
        end
    endtask

    task automatic test_first_edge();
        int rises[$];
        logic [NCH-1:0] prev;
        do_reset();
        en = '1;
        for (int c = 1; c <= 20; c++) begin
            prev = clkout;
            step();
            if (clkout[0] && !prev[0]) rises.push_back(c);
            n_chk++;
            if (clkout !== m_lvl || tick !== m_tick || pending !== exp_pend()) begin
                n_fail++;
                $display("FAIL first_edge c%0d clk=%b/%b tick=%b/%b pend=%b/%b",
                    c, clkout, m_lvl, tick, m_tick, pending, exp_pend());
            end
        end
        n_chk++;
        if (rises.size() != 3 || rises[0] != 4 || rises[1] != 12 || rises[2] != 20) begin
            n_fail++;
            $display("FAIL first_edge_rises n=%0d r0=%0d r1=%0d want 3 rises at 4,12,20",
                rises.size(), rises[0], rises[1]);
        end
    endtask

    task automatic test_write_midhalf();
        int tg[$];
        logic [NCH-1:0] prev;
        do_reset();
        en = '1;
        for (int c = 1; c <= 9; c++) begin
            wr_en = (c == 3); wr_ch = 0; wr_half = 2;
            prev = clkout;
            step();
            wr_en = 1'b0;
            if (clkout[0] != prev[0]) tg.push_back(c);
            n_chk++;
            if (clkout !== m_lvl || tick !== m_tick || pending !== exp_pend()) begin
                n_fail++;
                $display("FAIL write_mid c%0d clk=%b/%b tick=%b/%b pend=%b/%b",
                    c, clkout, m_lvl, tick, m_tick, pending, exp_pend());
            end
            if (c == 3) begin
                n_chk++;
                if (pending[0] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL write_mid_pend1 got %b want 1", pending[0]);
                end
            end
            if (c == 4) begin
                n_chk++;
                if (pending[0] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL write_mid_pend0 got %b want 0", pending[0]);
                end
            end
        end
        n_chk++;
        if (tg.size() != 3 || tg[0] != 4 || tg[1] != 6 || tg[2] != 8) begin
            n_fail++;
            $display("FAIL write_mid_toggles n=%0d t=%0d,%0d,%0d want 4,6,8",
                tg.size(), tg[0], tg[1], tg[2]);
        end
    endtask

    task automatic test_write_on_boundary();
        int tg[$];
        logic [NCH-1:0] prev;
        do_reset();
        en = '1;
        for (int c = 1; c <= 12; c++) begin
            wr_en = (c == 4); wr_ch = 0; wr_half = 2;
            prev = clkout;
            step();
            wr_en = 1'b0;
            if (clkout[0] != prev[0]) tg.push_back(c);
            n_chk++;
            if (clkout !== m_lvl || tick !== m_tick || pending !== exp_pend()) begin
                n_fail++;
                $display("FAIL write_bnd c%0d clk=%b/%b tick=%b/%b pend=%b/%b",
                    c, clkout, m_lvl, tick, m_tick, pending, exp_pend());
            end
            if (c == 4 && pending[0] !== 1'b1) begin
                n_fail++;
                $display("FAIL write_bnd_pend got %b want 1", pending[0]);
            end
        end
        n_chk++;
        if (tg.size() != 4 || tg[0] != 4 || tg[1] != 8 || tg[2] != 10 || tg[3] != 12) begin
            n_fail++;
            $display("FAIL write_bnd_toggles n=%0d t=%0d,%0d,%0d want 4,8,10,12",
                tg.size(), tg[0], tg[1], tg[2]);
        end
    endtask

    task automatic test_enable_freeze();
        int t0[$];
        int t1[$];
        logic [NCH-1:0] prev;
        do_reset();
        en = '1;
        for (int c = 1; c <= 20; c++) begin
            en[1] = !(c >= 7 && c <= 13);
            prev = clkout;
            step();
            if (clkout[0] != prev[0]) t0.push_back(c);
            if (clkout[1] != prev[1]) t1.push_back(c);
            n_chk++;
            if (clkout !== m_lvl || tick !== m_tick || pending !== exp_pend()) begin
                n_fail++;
                $display("FAIL freeze c%0d clk=%b/%b tick=%b/%b pend=%b/%b",
                    c, clkout, m_lvl, tick, m_tick, pending, exp_pend());
            end
        end
        n_chk++;
        if (t1.size() != 3 || t1[0] != 4 || t1[1] != 15 || t1[2] != 19) begin
            n_fail++;
            $display("FAIL freeze_ch1 n=%0d t=%0d,%0d,%0d want 4,15,19",
                t1.size(), t1[0], t1[1], t1[2]);
        end
        n_chk++;
        if (t0.size() != 5 || t0[1] != 8 || t0[4] != 20) begin
            n_fail++;
            $display("FAIL freeze_ch0 n=%0d t1=%0d t4=%0d want 5,8,20",
                t0.size(), t0[1], t0[4]);
        end
    endtask

    task automatic test_park();
        int t2[$];
        logic [NCH-1:0] prev;
        do_reset();
        en = '1;
        for (int c = 1; c <= 24; c++) begin
            wr_en = (c == 6 || c == 11 || c == 22);
            wr_ch = (c == 22) ? 2'd3 : 2'd2;
            wr_half = (c == 6) ? 16'd0 : (c == 11) ? 16'd3 : 16'd7;
            prev = clkout;
            step();
            wr_en = 1'b0;
            if (clkout[2] != prev[2]) t2.push_back(c);
            n_chk++;
            if (clkout !== m_lvl || tick !== m_tick || pending !== exp_pend()) begin
                n_fail++;
                $display("FAIL park c%0d clk=%b/%b tick=%b/%b pend=%b/%b",
                    c, clkout, m_lvl, tick, m_tick, pending, exp_pend());
            end
            if (c == 22 && pending !== '0) begin
                n_fail++;
                $display("FAIL park_badch pend=%b want 000", pending);
            end
        end
        n_chk++;
        if (t2.size() != 6 || t2[0] != 4 || t2[1] != 8 || t2[2] != 15
            || t2[3] != 18 || t2[4] != 21 || t2[5] != 24) begin
            n_fail++;
            $display("FAIL park_toggles n=%0d t=%0d,%0d,%0d,%0d want 4,8,15,18,21,24",
                t2.size(), t2[0], t2[1], t2[2], t2[3]);
        end
    endtask

    task automatic test_sync();
        int t0[$];
        logic [NCH-1:0] prev;
        do_reset();
        en = '1;
        for (int c = 1; c <= 30; c++) begin
            en[2] = !(c >= 2 && c <= 4);
            wr_en = (c == 1); wr_ch = 1; wr_half = 3;
            sync = (c == 10);
            prev = clkout;
            step();
            wr_en = 1'b0; sync = 1'b0;
            if (c > 10 && clkout[0] != prev[0]) t0.push_back(c);
            n_chk++;
            if (clkout !== m_lvl || tick !== m_tick || pending !== exp_pend()) begin
                n_fail++;
                $display("FAIL sync c%0d clk=%b/%b tick=%b/%b pend=%b/%b",
                    c, clkout, m_lvl, tick, m_tick, pending, exp_pend());
            end
            if (c == 10 && clkout !== '0) begin
                n_fail++;
                $display("FAIL sync_zero clk=%b want 000", clkout);
            end
            if (c > 10 && clkout[0] !== clkout[2]) begin
                n_fail++;
                $display("FAIL sync_lock c%0d ch0=%b ch2=%b want equal", c, clkout[0], clkout[2]);
            end
        end
        n_chk++;
        if (t0.size() < 1 || t0[0] != 14) begin
            n_fail++;
            $display("FAIL sync_first n=%0d t=%0d want 14", t0.size(), t0[0]);
        end
    endtask

    task automatic test_half_one();
        int nt;
        nt = 0;
        do_reset();
        en = '1;
        for (int c = 1; c <= 12; c++) begin
            wr_en = (c == 1); wr_ch = 0; wr_half = 1;
            step();
            wr_en = 1'b0;
            if (c >= 5 && tick[0]) nt++;
            n_chk++;
            if (clkout !== m_lvl || tick !== m_tick || pending !== exp_pend()) begin
                n_fail++;
                $display("FAIL half1 c%0d clk=%b/%b tick=%b/%b pend=%b/%b",
                    c, clkout, m_lvl, tick, m_tick, pending, exp_pend());
            end
        end
        n_chk++;
        if (nt != 4) begin
            n_fail++;
            $display("FAIL half1_ticks got %0d want 4", nt);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 1; c <= 400; c++) begin
            en = NCH'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) en = '1;
            wr_en = ($urandom_range(0, 5) == 0);
            wr_ch = CHW'($urandom_range(0, 3));
            wr_half = CW'($urandom_range(0, 5));
            sync = ($urandom_range(0, 39) == 0);
            step();
            n_chk++;
            if (clkout !== m_lvl || tick !== m_tick || pending !== exp_pend()) begin
                n_fail++;
                $display("FAIL random c%0d clk=%b/%b tick=%b/%b pend=%b/%b",
                    c, clkout, m_lvl, tick, m_tick, pending, exp_pend());
            end
        end
        wr_en = 1'b0; sync = 1'b0;
    endtask

    task automatic test_reset_midop();
        do_reset();
        en = '1;
        wr_en = 1'b1; wr_ch = 1; wr_half = 9;
        for (int c = 1; c <= 5; c++) step();
        wr_en = 1'b0;
        rst_n = 1'b0;
        #1;
        n_chk++;
        if (clkout !== '0 || tick !== '0 || pending !== '0) begin
            n_fail++;
            $display("FAIL reset_mid clk=%b tick=%b pend=%b want 000", clkout, tick, pending);
        end
        model_reset();
        @(negedge clkin);
        rst_n = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            step();
            n_chk++;
            if (clkout !== m_lvl || tick !== m_tick || pending !== exp_pend()) begin
                n_fail++;
                $display("FAIL reset_mid_run c%0d clk=%b/%b tick=%b/%b pend=%b/%b",
                    c, clkout, m_lvl, tick, m_tick, pending, exp_pend());
            end
        end
    endtask

    initial begin
        @(negedge clkin);
        test_reset();
        test_first_edge();
        test_write_midhalf();
        test_write_on_boundary();
        test_enable_freeze();
        test_park();
        test_sync();
        test_half_one();
        test_random();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
